// File: rtl/timer_service_master.sv
// timer_service_master: Avalon-MM master that programs the interval timer and services its IRQs
module timer_service_master #(
  parameter int TICK_W  = 16,
  parameter bit SNAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  output logic              cfg_err,
  output logic              busy,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR_STS,
    SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP, WR_STOP
  } state_t;
  state_t      state;
  state_t      after_svc;
  logic [31:0] period_q;
  logic [31:0] snap_q;
  logic [15:0] snap_lo;
  logic        stop_pending;
  logic        stop_now;
  assign stop_now  = stop_pending | cfg_stop;
  assign after_svc = stop_now ? WR_STOP : WAIT_IRQ;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      period_q     <= '0;
      snap_q       <= '0;
      snap_lo      <= '0;
      stop_pending <= 1'b0;
      tick_count   <= '0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (state == IDLE || state == WR_STOP) stop_pending <= 1'b0;
      else if (cfg_stop) stop_pending <= 1'b1;
      case (state)
        IDLE:
          if (cfg_start && !cfg_stop) begin
            if (cfg_period == '0) cfg_err <= 1'b1;
            else begin
              period_q   <= cfg_period;
              tick_count <= '0;
              state      <= WR_PL;
            end
          end
        WR_PL:   state <= WR_PH;
        WR_PH:   state <= WR_CTRL;
        WR_CTRL: state <= after_svc;
        WAIT_IRQ:
          if (stop_now) state <= WR_STOP;
          else if (tmr_irq) begin
            state      <= CLR_STS;
            tick_count <= tick_count + 1'b1;
          end
        CLR_STS:  state <= SNAP_EN ? SNAP_WR : after_svc;
        SNAP_WR:  state <= SNAP_RDL;
        SNAP_RDL: state <= SNAP_RDH;
        SNAP_RDH: begin
          snap_lo <= tmr_readdata;
          state   <= SNAP_CAP;
        end
        SNAP_CAP: begin
          snap_q <= {tmr_readdata, snap_lo};
          state  <= after_svc;
        end
        default: state <= IDLE;
      endcase
    end
  assign busy       = state != IDLE;
  assign tick_pulse = state == CLR_STS;
  assign snap_valid = state == SNAP_CAP;
  // the high half arrives on the bus during SNAP_CAP, so present it directly with its valid pulse
  assign snap_value = snap_valid ? {tmr_readdata, snap_lo} : snap_q;
  always_comb begin
    tmr_chipselect = !(state inside {IDLE, WAIT_IRQ, SNAP_CAP});
    tmr_write_n    = !(state inside {WR_PL, WR_PH, WR_CTRL, CLR_STS, SNAP_WR, WR_STOP});
    tmr_address    = state == WR_PL ? 3'd2 :
                     state == WR_PH ? 3'd3 :
                     state inside {WR_CTRL, WR_STOP} ? 3'd1 :
                     state inside {SNAP_WR, SNAP_RDL} ? 3'd4 :
                     state == SNAP_RDH ? 3'd5 : 3'd0;
    tmr_writedata  = state == WR_PL ? period_q[15:0] :
                     state == WR_PH ? period_q[31:16] :
                     state == WR_CTRL ? 16'h0007 :
                     state == WR_STOP ? 16'h0008 : 16'h0000;
  end
endmodule
